// File: rtl/conv2_window_buf.sv
// rtl/conv2_window_buf.sv - sliding-window line buffer feeding the second conv layer
//
// Takes one 4-channel int8 time-step per accepted beat and emits TAPS-long
// windows per channel, every STRIDE positions, never straddling a frame.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input beat handshake; in_sof marks frame start
//   in_ch1..in_ch4      signed int8 channel samples for one time-step
//   win1..win4          packed [TAPS-1:0][7:0] windows, [0] is the oldest sample
//   out_valid/out_ready window handshake
//   win_idx             window index within the frame
//   frame_done          one-cycle pulse after the last sample of a frame
module conv2_window_buf #(
  parameter int TAPS    = 5,
  parameter int STRIDE  = 1,
  parameter int SEQ_LEN = 90
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sof,
  input  logic [7:0]             in_ch1,
  input  logic [7:0]             in_ch2,
  input  logic [7:0]             in_ch3,
  input  logic [7:0]             in_ch4,
  output logic [TAPS-1:0][7:0]   win1,
  output logic [TAPS-1:0][7:0]   win2,
  output logic [TAPS-1:0][7:0]   win3,
  output logic [TAPS-1:0][7:0]   win4,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             win_idx,
  output logic                   frame_done
);

  localparam logic [7:0] FIRST  = 8'(TAPS - 1);
  localparam logic [7:0] LAST   = 8'(SEQ_LEN - 1);
  localparam logic [7:0] STR_M1 = 8'(STRIDE - 1);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_LAST} state_t;

  state_t               state;
  logic [TAPS-1:0][7:0] sh    [4];
  logic [TAPS-1:0][7:0] win_r [4];
  logic [TAPS-1:0][7:0] nsh   [4];
  logic [7:0]           ch_in [4];
  logic [7:0]           pos_cnt;
  logic [7:0]           ph;
  logic [7:0]           wcnt;

  logic       accept;
  logic       emit;
  logic [7:0] i;
  logic [7:0] ph_cur;
  logic [7:0] ph_nxt;
  logic [7:0] idx;

  assign ch_in[0] = in_ch1;
  assign ch_in[1] = in_ch2;
  assign ch_in[2] = in_ch3;
  assign ch_in[3] = in_ch4;

  assign win1 = win_r[0];
  assign win2 = win_r[1];
  assign win3 = win_r[2];
  assign win4 = win_r[3];

  // Upstream may only push when any window we hold can leave on this same edge.
  assign in_ready = !rst && (state != S_LAST) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    // A start-of-frame beat restarts the position count at zero.
    i      = in_sof ? 8'd0 : pos_cnt;
    // The first full window always starts a fresh stride phase and index,
    // so leftovers from an aborted frame never leak into the new one.
    ph_cur = (i == FIRST) ? 8'd0 : ph;
    idx    = (i == FIRST) ? 8'd0 : wcnt;
    ph_nxt = (ph_cur == STR_M1) ? 8'd0 : ph_cur + 8'd1;
    emit   = accept && (i >= FIRST) && (ph_cur == 8'd0);
    for (int c = 0; c < 4; c++) begin
      nsh[c] = in_sof ? {ch_in[c], {(TAPS-1){8'd0}}}
                      : {ch_in[c], sh[c][TAPS-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FILL;
      pos_cnt    <= 8'd0;
      ph         <= 8'd0;
      wcnt       <= 8'd0;
      out_valid  <= 1'b0;
      win_idx    <= 8'd0;
      frame_done <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        sh[c]    <= '0;
        win_r[c] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      if (state == S_LAST) begin
        state   <= S_FILL;
        pos_cnt <= 8'd0;
        ph      <= 8'd0;
        wcnt    <= 8'd0;
        for (int c = 0; c < 4; c++) sh[c] <= '0;
      end else if (accept) begin
        for (int c = 0; c < 4; c++) sh[c] <= nsh[c];
        pos_cnt <= i + 8'd1;
        if (i >= FIRST) ph <= ph_nxt;
        if (emit) wcnt <= idx + 8'd1;
        if (i == LAST) begin
          state      <= S_LAST;
          frame_done <= 1'b1;
        end else if (i >= FIRST) begin
          state <= S_RUN;
        end else begin
          state <= S_FILL;
        end
      end

      if (emit) begin
        for (int c = 0; c < 4; c++) win_r[c] <= nsh[c];
        out_valid <= 1'b1;
        win_idx   <= idx;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv2_window_buf.sv
// tb/tb_conv2_window_buf.sv - scoreboard bench for conv2_window_buf
module tb_conv2_window_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b0;
  logic [7:0] in_ch1 = '0, in_ch2 = '0, in_ch3 = '0, in_ch4 = '0;
  logic in_ready, out_valid, frame_done;
  logic [4:0][7:0] win1, win2, win3, win4;
  logic [7:0] win_idx;

  logic b_in_valid = 1'b0, b_in_sof = 1'b0, b_out_ready = 1'b1;
  logic [7:0] b_ch1 = '0, b_ch2 = '0, b_ch3 = '0, b_ch4 = '0;
  logic b_in_ready, b_out_valid, b_frame_done;
  logic [4:0][7:0] b_win1, b_win2, b_win3, b_win4;
  logic [7:0] b_win_idx;

  conv2_window_buf #(.TAPS(5), .STRIDE(1), .SEQ_LEN(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_ch1(in_ch1), .in_ch2(in_ch2), .in_ch3(in_ch3), .in_ch4(in_ch4),
    .win1(win1), .win2(win2), .win3(win3), .win4(win4),
    .out_valid(out_valid), .out_ready(out_ready), .win_idx(win_idx), .frame_done(frame_done));

  conv2_window_buf #(.TAPS(5), .STRIDE(2), .SEQ_LEN(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sof(b_in_sof),
    .in_ch1(b_ch1), .in_ch2(b_ch2), .in_ch3(b_ch3), .in_ch4(b_ch4),
    .win1(b_win1), .win2(b_win2), .win3(b_win3), .win4(b_win4),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .win_idx(b_win_idx), .frame_done(b_frame_done));

  typedef struct {
    logic [4:0][7:0] w1, w2, w3, w4;
    logic [7:0]      idx;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e;
  logic [7:0] ha [4][8];
  logic [7:0] hb [4][8];
  int pos_a = 0, pos_b = 0, p;
  logic fd_exp = 1'b0;
  int na = 0, nb = 0;
  int total = 0, bad = 0;

  // Reference model and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      q_a.delete(); q_b.delete();
      pos_a = 0; pos_b = 0; fd_exp = 1'b0;
    end else begin
      total = total + 1;
      if (frame_done !== fd_exp) begin
        bad = bad + 1;
        $display("FAIL frame_done: got %b want %b at %0t", frame_done, fd_exp, $time);
      end
      fd_exp = 1'b0;

      if (out_valid && out_ready) begin
        total = total + 1;
        na = na + 1;
        if (q_a.size() == 0) begin
          bad = bad + 1;
          $display("FAIL a_unexpected_window: got idx %0d win1 %h, none expected", win_idx, win1);
        end else begin
          e = q_a.pop_front();
          if ({win1, win2, win3, win4, win_idx} !== {e.w1, e.w2, e.w3, e.w4, e.idx}) begin
            bad = bad + 1;
            $display("FAIL a_window: got idx %0d %h %h %h %h want idx %0d %h %h %h %h",
                     win_idx, win1, win2, win3, win4, e.idx, e.w1, e.w2, e.w3, e.w4);
          end
        end
      end

      if (in_valid && in_ready) begin
        p = in_sof ? 0 : pos_a;
        ha[0][p] = in_ch1; ha[1][p] = in_ch2; ha[2][p] = in_ch3; ha[3][p] = in_ch4;
        if (p >= 4) begin
          for (int k = 0; k < 5; k++) begin
            e.w1[k] = ha[0][p-4+k]; e.w2[k] = ha[1][p-4+k];
            e.w3[k] = ha[2][p-4+k]; e.w4[k] = ha[3][p-4+k];
          end
          e.idx = 8'(p - 4);
          q_a.push_back(e);
        end
        if (p == 7) begin fd_exp = 1'b1; pos_a = 0; end
        else pos_a = p + 1;
      end

      if (b_out_valid && b_out_ready) begin
        total = total + 1;
        nb = nb + 1;
        if (q_b.size() == 0) begin
          bad = bad + 1;
          $display("FAIL b_unexpected_window: got idx %0d win1 %h, none expected", b_win_idx, b_win1);
        end else begin
          e = q_b.pop_front();
          if ({b_win1, b_win2, b_win3, b_win4, b_win_idx} !== {e.w1, e.w2, e.w3, e.w4, e.idx}) begin
            bad = bad + 1;
            $display("FAIL b_window: got idx %0d %h %h %h %h want idx %0d %h %h %h %h",
                     b_win_idx, b_win1, b_win2, b_win3, b_win4, e.idx, e.w1, e.w2, e.w3, e.w4);
          end
        end
      end

      if (b_in_valid && b_in_ready) begin
        p = b_in_sof ? 0 : pos_b;
        hb[0][p] = b_ch1; hb[1][p] = b_ch2; hb[2][p] = b_ch3; hb[3][p] = b_ch4;
        if (p >= 4 && ((p - 4) % 2) == 0) begin
          for (int k = 0; k < 5; k++) begin
            e.w1[k] = hb[0][p-4+k]; e.w2[k] = hb[1][p-4+k];
            e.w3[k] = hb[2][p-4+k]; e.w4[k] = hb[3][p-4+k];
          end
          e.idx = 8'((p - 4) / 2);
          q_b.push_back(e);
        end
        pos_b = (p == 7) ? 0 : p + 1;
      end
    end
  end

  // All tasks start and return at posedge+1.
  task automatic send(input logic [7:0] c1, c2, c3, c4, input logic sof);
    int n;
    in_ch1 = c1; in_ch2 = c2; in_ch3 = c3; in_ch4 = c4;
    in_sof = sof; in_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] c1, c2, c3, c4);
    int n;
    b_ch1 = c1; b_ch2 = c2; b_ch3 = c3; b_ch4 = c4;
    b_in_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!b_in_ready && n < 20) begin @(negedge clk); n++; end
    if (!b_in_ready) begin
      total++; bad++;
      $display("FAIL send_b_timeout: b_in_ready got %b want 1", b_in_ready);
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic drain_and_count(input string name, input int want);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (na !== want || q_a.size() != 0) begin
      bad++;
      $display("FAIL %s_count: got %0d windows (%0d pending) want %0d", name, na, q_a.size(), want);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || win1 !== 40'h0 || win4 !== 40'h0 || win_idx !== 8'd0 ||
        frame_done !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: ov %b w1 %h w4 %h idx %0d fd %b rdy %b want all 0",
               out_valid, win1, win4, win_idx, frame_done, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1; na = 0;
    for (int k = 1; k <= 8; k++) begin
      send(8'(k), 8'(k + 16), 8'(-k), 8'(3 * k), 1'b0);
      if (k == 5) begin
        total++;
        if (out_valid !== 1'b1 || win1 !== 40'h0504030201 || win_idx !== 8'd0) begin
          bad++;
          $display("FAIL first_window_latency: ov %b w1 %h idx %0d want 1 0504030201 0",
                   out_valid, win1, win_idx);
        end
      end
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || frame_done !== 1'b1) begin
      bad++;
      $display("FAIL last_state: in_ready %b frame_done %b want 0 1", in_ready, frame_done);
    end
    @(posedge clk); #1;
    drain_and_count("back_to_back", 4);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0; na = 0;
    for (int k = 1; k <= 5; k++) send(8'(10 + k), 8'(40 + k), 8'(70 + k), 8'(100 + k), 1'b0);
    in_ch1 = 8'd16; in_ch2 = 8'd46; in_ch3 = 8'd76; in_ch4 = 8'd106; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || win1 !== 40'h0f0e0d0c0b || win_idx !== 8'd0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d: ov %b w1 %h idx %0d rdy %b want 1 0f0e0d0c0b 0 0",
                 c, out_valid, win1, win_idx, in_ready);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 6; k <= 8; k++) send(8'(10 + k), 8'(40 + k), 8'(70 + k), 8'(100 + k), 1'b0);
    drain_and_count("backpressure", 4);
  endtask

  task automatic test_sof_abort;
    out_ready = 1'b1; na = 0;
    for (int k = 1; k <= 3; k++) send(8'(20 + k), 8'(k), 8'(k), 8'(k), 1'b0);
    for (int k = 0; k < 8; k++) begin
      send(8'(30 + k), 8'(60 + k), 8'(90 + k), 8'(120 + k), (k == 0));
      if (k == 4) begin
        total++;
        if (out_valid !== 1'b1 || win1 !== 40'h2221201f1e || win_idx !== 8'd0) begin
          bad++;
          $display("FAIL sof_first_window: ov %b w1 %h idx %0d want 1 2221201f1e 0",
                   out_valid, win1, win_idx);
        end
      end
    end
    drain_and_count("sof_abort", 4);
  endtask

  task automatic test_signed;
    logic [7:0] vals [5];
    vals[0] = 8'h80; vals[1] = 8'h81; vals[2] = 8'h7f; vals[3] = 8'h00; vals[4] = 8'hff;
    out_ready = 1'b1; na = 0;
    for (int k = 0; k < 8; k++) begin
      send(vals[k % 5], vals[(k + 1) % 5], vals[(k + 2) % 5], vals[(k + 3) % 5], 1'b0);
      if (k == 4) begin
        total++;
        if (win1 !== 40'hff007f8180 || win4 !== 40'h7f8180ff00) begin
          bad++;
          $display("FAIL signed_window: w1 %h w4 %h want ff007f8180 7f8180ff00", win1, win4);
        end
      end
    end
    drain_and_count("signed", 4);
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send(8'(k), 8'(k), 8'(k), 8'(k), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || win1 !== 40'h0 || win2 !== 40'h0 || win_idx !== 8'd0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: ov %b w1 %h w2 %h idx %0d rdy %b want 0 0 0 0 0",
               out_valid, win1, win2, win_idx, in_ready);
    end
    rst = 1'b0; out_ready = 1'b1; na = 0;
    for (int k = 1; k <= 8; k++) begin
      send(8'(50 + k), 8'(k), 8'(2 * k), 8'(200 + k), 1'b0);
      if (k == 5) begin
        total++;
        if (out_valid !== 1'b1 || win1 !== 40'h3736353433 || win_idx !== 8'd0) begin
          bad++;
          $display("FAIL reset_restart: ov %b w1 %h idx %0d want 1 3736353433 0",
                   out_valid, win1, win_idx);
        end
      end
    end
    drain_and_count("reset_mid", 4);
  endtask

  task automatic test_stride;
    nb = 0;
    for (int k = 1; k <= 8; k++) send_b(8'(k), 8'(k + 100), 8'(-k), 8'(k * 5));
    @(negedge clk);
    total++;
    if (b_frame_done !== 1'b1) begin
      bad++;
      $display("FAIL stride_frame_done: got %b want 1", b_frame_done);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (nb !== 2 || q_b.size() != 0) begin
      bad++;
      $display("FAIL stride_count: got %0d windows (%0d pending) want 2", nb, q_b.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_sof_abort();
    test_signed();
    test_reset_mid();
    test_stride();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
